// File: rtl/layer2_argmax_pkg.sv
// Shared definitions for the MNIST MLP output stage (layer2_argmax).
// Holds the network dimensions, the Q8.8 data widths, the SDRAM memory map and
// the FSM state encoding. Each state is an 8-bit code so it can be shown directly
// on the HEX LEDs through the debug word.
package layer2_argmax_pkg;

  localparam int N_HID   = 200;  // hidden activations from layer 1
  localparam int N_OUT   = 10;   // output classes (digits)
  localparam int DATA_W  = 16;   // Q8.8 signed word
  localparam int FRAC_W  = 8;    // fractional bits of a Q8.8 word
  localparam int PROD_W  = 2 * DATA_W;
  localparam int ACC_W   = 40;   // 200 * 2^30 < 2^39, so no saturation is needed
  localparam int ELEM_W  = 8;    // element counter, 0..N_HID-1
  localparam int CLASS_W = 4;    // class counter, 0..N_OUT-1
  localparam int WIDX_W  = 11;   // running W2 word index, 0..N_OUT*N_HID-1

  localparam logic [ELEM_W-1:0]  LAST_ELEM  = ELEM_W'(N_HID - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(N_OUT - 1);

  // SDRAM byte addresses
  localparam logic [31:0] HID_BASE    = 32'd400_000;
  localparam logic [31:0] W2_BASE     = 32'd314_400;
  localparam logic [31:0] RESULT_ADDR = 32'd450_000;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'h00,
    ST_LD_REQ   = 8'h01,
    ST_LD_WAIT  = 8'h02,
    ST_MAC_REQ  = 8'h03,
    ST_MAC_WAIT = 8'h04,
    ST_CMP      = 8'h05,
    ST_WR_REQ   = 8'h06,
    ST_DONE     = 8'h07
  } state_e;

  // Negative activations are clamped to zero.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] h);
    return h[DATA_W-1] ? '0 : h;
  endfunction

  // Byte address of 16-bit word number idx in a table starting at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 1);
  endfunction

endpackage

// File: rtl/layer2_argmax_if.sv
// Avalon-MM master/slave connection between layer2_argmax and the SDRAM
// controller (16-bit data, byte addresses).
//   chipselect, byteenable, read_n, write_n, address, writedata : master -> slave
//   waitrequest, readdatavalid, readdata                         : slave -> master
// Handshake: a transfer is requested while read_n=0 or write_n=0; it is
// accepted on the clock edge where waitrequest=0 is sampled. Until then the
// strobe, address and writedata hold steady. Read data returns later with
// readdatavalid=1; the master keeps at most one read outstanding.
interface layer2_argmax_if;
  import layer2_argmax_pkg::*;

  logic              chipselect;
  logic [1:0]        byteenable;
  logic              read_n;
  logic              write_n;
  logic [31:0]       address;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, byteenable, read_n, write_n, address, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  chipselect, byteenable, read_n, write_n, address, writedata,
    output waitrequest, readdatavalid, readdata
  );

endinterface

// File: rtl/layer2_argmax_hid_buffer.sv
// Local store for the ReLU'd hidden vector: N_HID x 16 single-port synchronous
// RAM with a registered read, written while loading and read during the MACs.
// Ports:
//   clk   : clock
//   we    : write enable (writes wdata to addr)
//   addr  : word address, shared by write and read
//   wdata : word to store
//   rdata : word at addr, one clock after addr is presented
module layer2_argmax_hid_buffer
  import layer2_argmax_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ELEM_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N_HID];

  // No reset: keeps the array mappable onto a block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/layer2_argmax.sv
// Output stage of the MNIST MLP. Loads the 200 hidden sums from SDRAM, applies
// ReLU into a local buffer, streams the 10x200 W2 matrix computing one MAC per
// class, keeps the running argmax and writes the winning digit back to SDRAM.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   start        : level request, sampled in IDLE; holding it keeps DONE
//   avm          : Avalon-MM master to the SDRAM controller
//   busy         : high from leaving IDLE until DONE is entered
//   done         : result valid and written
//   digit        : argmax class index
//   dbg          : {best_idx, class_cnt, elem_cnt, state, last readdata[7:0]}
module layer2_argmax
  import layer2_argmax_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  layer2_argmax_if.master      avm,
  output logic                 busy,
  output logic                 done,
  output logic [CLASS_W-1:0]   digit,
  output logic [31:0]          dbg
);

  state_e                   state_q, state_d;
  logic [ELEM_W-1:0]        elem_q, elem_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic [WIDX_W-1:0]        widx_q, widx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  best_q, best_d;
  logic [CLASS_W-1:0]       best_idx_q, best_idx_d;
  logic                     read_n_q, read_n_d;
  logic                     write_n_q, write_n_d;
  logic [31:0]              address_q, address_d;
  logic [DATA_W-1:0]        writedata_q, writedata_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [CLASS_W-1:0]       digit_q, digit_d;
  logic [7:0]               last_rd_q;

  logic                     buf_we;
  logic [DATA_W-1:0]        buf_wdata;
  logic [DATA_W-1:0]        buf_rdata;

  logic [ELEM_W-1:0]        elem_inc;
  logic [CLASS_W-1:0]       class_inc;
  logic [WIDX_W-1:0]        widx_inc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  mac_sum;
  logic                     take;

  // Buffer is addressed by elem_q, which is stable throughout MAC_REQ, so the
  // registered read data is valid by the time readdatavalid arrives.
  layer2_argmax_hid_buffer u_hid_buffer (
    .clk   (clk),
    .we    (buf_we),
    .addr  (elem_q),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  assign elem_inc  = elem_q + 1'b1;
  assign class_inc = class_q + 1'b1;
  assign widx_inc  = widx_q + 1'b1;
  assign prod      = $signed(buf_rdata) * $signed(avm.readdata);
  assign mac_sum   = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  // Strictly greater keeps the lowest index on ties.
  assign take      = (class_q == '0) || (acc_q > best_q);

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    class_d     = class_q;
    widx_d      = widx_q;
    acc_d       = acc_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    digit_d     = digit_q;
    buf_we      = 1'b0;
    buf_wdata   = relu(avm.readdata);

    // Strobes and address are registered: each transition into a *_REQ state
    // also sets up the request seen by the slave in that state.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LD_REQ;
          elem_d     = '0;
          class_d    = '0;
          best_idx_d = '0;
          busy_d     = 1'b1;
          read_n_d   = 1'b0;
          address_d  = HID_BASE;
        end
      end

      ST_LD_REQ: begin
        if (!avm.waitrequest) begin
          state_d  = ST_LD_WAIT;
          read_n_d = 1'b1;
        end
      end

      ST_LD_WAIT: begin
        if (avm.readdatavalid) begin
          buf_we   = 1'b1;
          read_n_d = 1'b0;
          if (elem_q == LAST_ELEM) begin
            state_d   = ST_MAC_REQ;
            elem_d    = '0;
            class_d   = '0;
            widx_d    = '0;
            acc_d     = '0;
            address_d = W2_BASE;
          end else begin
            state_d   = ST_LD_REQ;
            elem_d    = elem_inc;
            address_d = word_addr(HID_BASE, 32'(elem_inc));
          end
        end
      end

      ST_MAC_REQ: begin
        if (!avm.waitrequest) begin
          state_d  = ST_MAC_WAIT;
          read_n_d = 1'b1;
        end
      end

      ST_MAC_WAIT: begin
        if (avm.readdatavalid) begin
          acc_d  = mac_sum;
          widx_d = widx_inc;
          if (elem_q == LAST_ELEM) begin
            state_d = ST_CMP;
          end else begin
            state_d   = ST_MAC_REQ;
            elem_d    = elem_inc;
            read_n_d  = 1'b0;
            address_d = word_addr(W2_BASE, 32'(widx_inc));
          end
        end
      end

      ST_CMP: begin
        if (take) begin
          best_d     = acc_q;
          best_idx_d = class_q;
        end
        if (class_q == LAST_CLASS) begin
          state_d     = ST_WR_REQ;
          write_n_d   = 1'b0;
          address_d   = RESULT_ADDR;
          writedata_d = {{(DATA_W - CLASS_W){1'b0}}, take ? class_q : best_idx_q};
        end else begin
          state_d   = ST_MAC_REQ;
          class_d   = class_inc;
          elem_d    = '0;
          acc_d     = '0;
          read_n_d  = 1'b0;
          // widx_q already points at the first word of the next row
          address_d = word_addr(W2_BASE, 32'(widx_q));
        end
      end

      ST_WR_REQ: begin
        if (!avm.waitrequest) begin
          state_d   = ST_DONE;
          write_n_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          digit_d   = best_idx_q;
        end
      end

      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      class_q     <= '0;
      widx_q      <= '0;
      acc_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      address_q   <= '0;
      writedata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      digit_q     <= '0;
      last_rd_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      class_q     <= class_d;
      widx_q      <= widx_d;
      acc_q       <= acc_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      digit_q     <= digit_d;
      if (avm.readdatavalid) last_rd_q <= avm.readdata[7:0];
    end
  end

  assign avm.chipselect = 1'b1;
  assign avm.byteenable = 2'b11;
  assign avm.read_n     = read_n_q;
  assign avm.write_n    = write_n_q;
  assign avm.address    = address_q;
  assign avm.writedata  = writedata_q;

  assign busy  = busy_q;
  assign done  = done_q;
  assign digit = digit_q;
  assign dbg   = {best_idx_q, class_q, elem_q, state_q, last_rd_q};

endmodule

// File: tb/tb_layer2_argmax.sv
// Testbench for layer2_argmax: Avalon SDRAM model with programmable
// waitrequest and readdatavalid latency, expected-address and expected-digit
// queues, and a linear sequence of directed runs.
module tb_layer2_argmax;
  import layer2_argmax_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [3:0] digit;
  logic [31:0] dbg;

  always #5 clk = ~clk;

  layer2_argmax_if bus ();

  layer2_argmax dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .avm     (bus),
    .busy    (busy),
    .done    (done),
    .digit   (digit),
    .dbg     (dbg)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_addr_q[$];
  logic [3:0]  exp_q[$];

  logic [15:0] mem [int];
  logic [15:0] h_arr [N_HID];
  logic [15:0] w_arr [N_OUT*N_HID];

  int lat_min = 1;
  int lat_max = 1;
  int stall_pct = 0;
  int rd_count = 0;
  int wr_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- Avalon SDRAM model ----------------
  bit          outstanding = 0;
  int          pend_lat = 0;
  logic [15:0] pend_data = '0;
  bit          stall_prev = 0;
  logic        sv_rn, sv_wn;
  logic [31:0] sv_addr;
  logic [15:0] sv_wd;

  initial begin
    logic [31:0] ea;
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.readdata      = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        outstanding = 0;
        pend_lat    = 0;
        stall_prev  = 0;
      end else begin
        if (stall_prev) begin
          check("stall_read_n", bus.read_n, sv_rn);
          check("stall_write_n", bus.write_n, sv_wn);
          check("stall_address", bus.address, sv_addr);
          check("stall_writedata", bus.writedata, sv_wd);
        end
        if (bus.readdatavalid) outstanding = 0;
        if (!bus.read_n && !bus.waitrequest) begin
          check("one_outstanding", outstanding, 0);
          ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hFFFF_FFFF;
          check("rd_addr", bus.address, ea);
          pend_data   = mem.exists(int'(bus.address)) ? mem[int'(bus.address)] : 16'hDEAD;
          pend_lat    = $urandom_range(lat_min, lat_max);
          outstanding = 1;
          rd_count++;
        end
        if (!bus.write_n && !bus.waitrequest) begin
          check("wr_addr", bus.address, RESULT_ADDR);
          check("wr_data", bus.writedata, (exp_q.size() > 0) ? {12'b0, exp_q[0]} : 16'hFFFF);
          wr_count++;
        end
        stall_prev = (!bus.read_n || !bus.write_n) && bus.waitrequest;
        sv_rn   = bus.read_n;
        sv_wn   = bus.write_n;
        sv_addr = bus.address;
        sv_wd   = bus.writedata;
      end
      @(negedge clk);
      bus.readdatavalid = 1'b0;
      bus.readdata      = 16'($urandom_range(0, 65535));
      if (outstanding && pend_lat > 0) begin
        pend_lat--;
        if (pend_lat == 0) begin
          bus.readdatavalid = 1'b1;
          bus.readdata      = pend_data;
        end
      end
      bus.waitrequest = ($urandom_range(0, 99) < stall_pct);
    end
  end

  // ---------------- reference and driver tasks ----------------
  function automatic logic [3:0] ref_digit();
    longint acc, best, hv;
    logic [3:0] bi;
    best = 0;
    bi = 0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_HID; i++) begin
        hv = h_arr[i][15] ? 64'sd0 : longint'(h_arr[i]);
        acc += hv * longint'($signed(w_arr[j*N_HID+i]));
      end
      if (j == 0 || acc > best) begin
        best = acc;
        bi = 4'(j);
      end
    end
    return bi;
  endfunction

  task automatic set_data(input int mode);
    logic [15:0] row [N_HID];
    for (int i = 0; i < N_HID; i++) row[i] = 16'($urandom_range(1, 65535));
    for (int i = 0; i < N_HID; i++) begin
      case (mode)
        1:       h_arr[i] = 16'h0100;
        2:       h_arr[i] = 16'($urandom_range(0, 16'h7FFF));
        3:       h_arr[i] = 16'hFF00;
        default: h_arr[i] = 16'($urandom_range(0, 65535));
      endcase
      for (int j = 0; j < N_OUT; j++) begin
        case (mode)
          1:       w_arr[j*N_HID+i] = (j == 3) ? 16'h0100 : 16'h0000;
          2:       w_arr[j*N_HID+i] = row[i];
          3:       w_arr[j*N_HID+i] = (j == 5) ? 16'hFF00 : 16'h0000;
          default: w_arr[j*N_HID+i] = 16'($urandom_range(0, 65535));
        endcase
      end
    end
  endtask

  task automatic load_and_expect(input logic [3:0] exp_digit);
    exp_addr_q.delete();
    for (int i = 0; i < N_HID; i++) begin
      mem[int'(HID_BASE) + 2*i] = h_arr[i];
      exp_addr_q.push_back(HID_BASE + 32'(2*i));
    end
    for (int k = 0; k < N_OUT*N_HID; k++) begin
      mem[int'(W2_BASE) + 2*k] = w_arr[k];
      exp_addr_q.push_back(W2_BASE + 32'(2*k));
    end
    exp_q.push_back(exp_digit);
  endtask

  task automatic run(input logic [3:0] exp_digit, input int hold);
    int rd0, wr0;
    bit seen;
    logic [3:0] e;
    load_and_expect(exp_digit);
    rd0 = rd_count;
    wr0 = wr_count;
    @(negedge clk);
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
    check("digit", digit, e);
    check("busy_at_done", busy, 0);
    check("dbg_done_state", dbg[15:8], ST_DONE);
    check("read_count", rd_count - rd0, 2200);
    check("write_count", wr_count - wr0, 1);
    check("addr_q_drained", exp_addr_q.size(), 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("done_held", done, 1);
    end
    if (hold > 0) check("no_extra_traffic", (rd_count - rd0) + (wr_count - wr0), 2201);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_clear", done, 0);
    check("back_to_idle", dbg[15:8], ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit seen;

    // reset state
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_n", bus.read_n, 1);
    check("rst_write_n", bus.write_n, 1);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_digit", digit, 0);
    check("rst_address", bus.address, 0);
    check("rst_writedata", bus.writedata, 0);
    check("rst_chipselect", bus.chipselect, 1);
    check("rst_byteenable", bus.byteenable, 2'b11);
    check("rst_state", dbg[15:8], ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: only row 3 responds
    set_data(1);
    run(4'd3, 0);

    // 2: identical rows, tie keeps class 0
    set_data(2);
    run(4'd0, 0);

    // 3: negative activations are clamped, all sums zero
    set_data(3);
    run(4'd0, 0);

    // 4: random data, random stalls and latency
    lat_min = 1;
    lat_max = 5;
    stall_pct = 30;
    set_data(4);
    run(ref_digit(), 0);
    lat_max = 1;
    stall_pct = 0;

    // 5: reset during MAC_WAIT of class 4, then rerun test 1
    set_data(1);
    load_and_expect(4'd3);
    @(negedge clk);
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (dbg[15:8] == ST_MAC_WAIT && dbg[27:24] == 4'd4) seen = 1;
    end
    check("reached_mac_wait_c4", seen, 1);
    reset_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort_read_n", bus.read_n, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_state", dbg[15:8], ST_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    exp_addr_q.delete();
    exp_q.delete();
    run(4'd3, 0);

    // 6: start held after done, then a second identical run
    run(4'd3, 20);
    run(4'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
